jk_cmd_sequencer: RTL
=====================

# jk_cmd_sequencer

Upstream driver for the `jk_flipflop` stage. It accepts JK commands (hold, reset, set, toggle) with a repeat length over a valid/ready handshake. For each command it drives the flip-flop's `j`/`k` inputs for exactly that many clock cycles, and it supports back-to-back commands with no bubble. An optional checker tracks the expected flip-flop state and flags any divergence of `q`.

## Interface
Parameters:
- `CNT_W`, default 8: width of the command length field and the internal down-counter.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command this cycle.
- `cmd_op`  in  2  operation code:
  - 00 = HOLD (j=0, k=0)
  - 01 = RESET (j=0, k=1)
  - 10 = SET (j=1, k=0)
  - 11 = TOGGLE (j=1, k=1)
- `cmd_len`  in  CNT_W  number of drive cycles; 0 is treated as 1.
- `j`  out  1  registered J drive to the flip-flop.
- `k`  out  1  registered K drive to the flip-flop.
- `busy`  out  1  a command is being driven.
- `done`  out  1  one-cycle pulse marking the final drive cycle of a command.
- `q`  in  1  flip-flop output, used only by the checker.
- `q_err`  out  1  sticky mismatch flag.

## Operation
States:
- IDLE: `cmd_ready`=1, `j`=`k`=0, `busy`=0.
- RUN: drive `cmd_op` onto `j`/`k`; a down-counter `rem` holds the remaining drive cycles.

Transitions:
- IDLE to RUN on a handshake (`cmd_valid` & `cmd_ready` at an edge). On that edge, latch op and load `rem` = max(`cmd_len`,1).
- In RUN, `rem` decrements each edge.
- `cmd_ready` = IDLE | (RUN & `rem`==1).
- Handshake while `rem`==1: reload op and `rem`, stay in RUN. This is back-to-back operation with no hold cycle inserted.
- `rem`==1 with no handshake: go to IDLE, `j`=`k`=0.

Other rules:
- `done` = RUN & `rem`==1.
- `busy` = RUN.
- The sequencer ignores `cmd_op`/`cmd_len` when no handshake occurs. A command cannot be cancelled once accepted.

Reset (`rst` low, asynchronous):
- Go to IDLE, `j`=`k`=0, `rem`=0, `q_err`=0.
- An in-flight command is discarded.
- Any handshake in the release cycle follows normal IDLE rules.

Width rules:
- `rem` is CNT_W bits; the maximum length is 2^CNT_W−1 cycles.
- `cmd_len`=0 yields exactly one drive cycle.

## Timing
- Handshake at edge N: `j`/`k` show the new op from N to N+L, where L = max(`cmd_len`,1). The flip-flop samples it on edges N+1 … N+L.
- Latency from handshake to first drive value: 1 cycle, because the drive outputs are registered.
- `done` is high in the cycle before edge N+L.
- Back-to-back: the next op appears on `j`/`k` from edge N+L, with no gap.
- Reset values: `cmd_ready`=1, `j`=0, `k`=0, `busy`=0, `done`=0, `q_err`=0.

## Configuration
Macro `JK_SEQ_QCHECK_EN`.

With the macro defined:
- Expected register `exp`, with valid bit `exp_v`, updates on every RUN edge:
  - RESET sets `exp` to 0 and `exp_v` to 1.
  - SET sets `exp` to 1 and `exp_v` to 1.
  - TOGGLE sets `exp` to ~`exp`.
  - HOLD leaves `exp` unchanged.
- When `exp_v`=1 and `q` ≠ `exp` in any cycle, `q_err` sets and stays set until reset.
- TOGGLE or HOLD issued before the first RESET or SET does not set `exp_v`.

Without the macro:
- The `q` port is present but ignored.
- `q_err` is tied to 0.
- No checker logic is synthesized.

## Structure
- Shared package `jk_seq_pkg`: op encodings (`OP_HOLD`, `OP_RESET`, `OP_SET`, `OP_TOGGLE`), the state enum (`ST_IDLE`, `ST_RUN`), and the default `CNT_W`.
- One sub-module, `jk_seq_qcheck`, holds the `exp`/`exp_v` model and the `q_err` flag. It is instantiated only under `JK_SEQ_QCHECK_EN`.

## Test plan
1. After reset, issue SET with len=3, then RESET with len=2, back-to-back.
   - `j`/`k` = 10,10,10,01,01, then 00.
   - `done` pulses in cycle 3 and cycle 5.
   - `cmd_ready` is low only during cycles 1–2 and 4.
2. Issue TOGGLE with `cmd_len`=0.
   - Exactly one cycle of `j`=`k`=1.
   - `done` is high in that cycle.
   - Returns to IDLE.
3. Issue HOLD with len=255 (CNT_W=8).
   - `busy` is high for 255 cycles, then `cmd_ready` returns high.
   - `j`=`k`=0 throughout.
4. Assert `rst` low mid-way through TOGGLE with len=10.
   - `j`=`k`=0 and IDLE immediately, with no clock edge required.
   - The next command after release starts cleanly.
5. With the macro, connect a real `jk_flipflop`. Issue RESET len=1, then TOGGLE len=4.
   - `q` follows 0,1,0,1,0.
   - `q_err` stays 0.
6. With the macro, force `q`=1 after RESET completes.
   - `q_err` rises within one cycle.
   - It stays high until `rst` is asserted.

Source files
------------

// File: rtl/jk_seq_pkg.sv
// Shared encodings for the JK command sequencer: op codes, FSM states, default width.
// The op encoding is chosen so that op[1] is the J drive and op[0] is the K drive.
package jk_seq_pkg;

  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_RESET  = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } jk_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } jk_state_e;

endpackage

// File: rtl/jk_cmd_sequencer_if.sv
// Command/drive bundle between a command source, the sequencer and the flip-flop under drive.
// Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready are both high;
// cmd_op/cmd_len are sampled only at that edge. cmd_ready does not depend on cmd_valid.
interface jk_cmd_sequencer_if
  import jk_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_len;
  logic             j;
  logic             k;
  logic             busy;
  logic             done;
  logic             q;
  logic             q_err;
  jk_state_e        state;

  modport master (
    output cmd_valid, cmd_op, cmd_len, q,
    input  cmd_ready, j, k, busy, done, q_err, state
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, q,
    output cmd_ready, j, k, busy, done, q_err, state
  );
endinterface

// File: rtl/jk_seq_qcheck.sv
// Shadow model of the driven JK flip-flop; raises a sticky q_err when the observed q diverges.
// Only instantiated when JK_SEQ_QCHECK_EN is defined.
module jk_seq_qcheck
  import jk_seq_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   run_i,
  input  jk_op_e op_i,
  input  logic   q_i,
  output logic   q_err_o
);
  logic exp_q, exp_d;
  logic exp_v_q, exp_v_d;
  logic q_err_q, q_err_d;

  // The flip-flop samples the same registered op on the same edge, so exp tracks q in lockstep.
  always_comb begin
    exp_d   = exp_q;
    exp_v_d = exp_v_q;
    if (run_i) begin
      case (op_i)
        OP_RESET:  begin exp_d = 1'b0;   exp_v_d = 1'b1; end
        OP_SET:    begin exp_d = 1'b1;   exp_v_d = 1'b1; end
        OP_TOGGLE: begin exp_d = ~exp_q; end
        default:   begin end
      endcase
    end
    q_err_d = q_err_q | (exp_v_q & (q_i != exp_q));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q   <= 1'b0;
      exp_v_q <= 1'b0;
      q_err_q <= 1'b0;
    end else begin
      exp_q   <= exp_d;
      exp_v_q <= exp_v_d;
      q_err_q <= q_err_d;
    end
  end

  assign q_err_o = q_err_q;
endmodule

// File: rtl/jk_cmd_sequencer.sv
// Drives registered J/K onto a flip-flop for cmd_len cycles per accepted command, back-to-back.
// Define JK_SEQ_QCHECK_EN to add the q divergence checker; otherwise q is ignored and q_err is 0.
module jk_cmd_sequencer
  import jk_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
)(
  input logic clk,
  input logic rst,
  jk_cmd_sequencer_if.slave bus
);
  jk_state_e        state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  jk_op_e           op_q, op_d;
  logic [CNT_W-1:0] len_eff;
  logic             last;
  logic             accept;

  assign last          = (state_q == ST_RUN) && (rem_q == CNT_W'(1));
  assign bus.cmd_ready = (state_q == ST_IDLE) || last;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign len_eff       = (bus.cmd_len == '0) ? CNT_W'(1) : bus.cmd_len;

  // A handshake on the final drive cycle reloads directly, so no idle bubble appears on j/k.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    op_d    = op_q;
    if (accept) begin
      state_d = ST_RUN;
      rem_d   = len_eff;
      op_d    = jk_op_e'(bus.cmd_op);
    end else if (last) begin
      state_d = ST_IDLE;
      rem_d   = '0;
      op_d    = OP_HOLD;
    end else if (state_q == ST_RUN) begin
      rem_d   = rem_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      op_q    <= OP_HOLD;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
    end
  end

  assign bus.j     = op_q[1];
  assign bus.k     = op_q[0];
  assign bus.busy  = (state_q == ST_RUN);
  assign bus.done  = last;
  assign bus.state = state_q;

`ifdef JK_SEQ_QCHECK_EN
  jk_seq_qcheck u_qcheck (
    .clk     (clk),
    .rst     (rst),
    .run_i   (state_q == ST_RUN),
    .op_i    (op_q),
    .q_i     (bus.q),
    .q_err_o (bus.q_err)
  );
`else
  logic unused_q;
  assign unused_q  = bus.q;
  assign bus.q_err = 1'b0;
`endif
endmodule
